// File: rtl/ifu_prefetch_if.sv
// Instruction-bus interface between the prefetch unit (master) and instruction memory (slave).
// One outstanding request at a time; responses return in order with no back-pressure.
interface ifu_prefetch_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input rvalid, rdata);
  modport slave  (input req, addr, output rvalid, rdata);
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction fetch unit: sequential prefetch into an in-order FIFO, redirect/flush, DRAIN of stale responses.
// Optional IFU_PERF_EN adds perf_fetches / perf_redirects counters.
module ifu_prefetch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_rdata,
  output logic [31:0] instr_pc,
  input  logic        branch,
  input  logic        relative_jump,
  input  logic        absolute_jump,
  input  logic [31:0] rf_rdata,
  input  logic [31:0] imm,
  ifu_prefetch_if.master ibus
`ifdef IFU_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_redirects
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rdata;
  } entry_t;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rptr, wptr;
  logic [CNT_W-1:0]  count, count_n;
  state_t            state, state_n;
  logic              outstanding, outstanding_n;
  logic [31:0]       fetch_pc, req_pc, target;
  logic              req_q, redirect, push, pop;

  assign redirect = (state == RUN) && (branch || relative_jump || absolute_jump);
  assign ibus.req  = req_q && !redirect;
  assign ibus.addr = fetch_pc;
  assign push     = ibus.rvalid && (state == RUN) && !redirect;
  assign pop      = instr_valid && instr_ready && !redirect;

  assign instr_valid = (count != '0);
  assign instr_rdata = instr_valid ? fifo_mem[rptr].rdata : 32'h0;
  assign instr_pc    = instr_valid ? fifo_mem[rptr].pc    : 32'h0;

  always_comb begin
    target = (rf_rdata + imm) & ~32'h1;
    if (branch || relative_jump) target = instr_pc + imm;
  end

  // Next values of the control state; req for the next cycle is decided from these.
  always_comb begin
    state_n       = state;
    outstanding_n = outstanding;
    count_n       = count;
    if (state == DRAIN) begin
      if (ibus.rvalid) begin
        state_n       = RUN;
        outstanding_n = 1'b0;
      end
    end else if (redirect) begin
      count_n = '0;
      if (outstanding && !ibus.rvalid) state_n = DRAIN;
      else                             outstanding_n = 1'b0;
    end else begin
      if (ibus.rvalid) outstanding_n = 1'b0;
      if (ibus.req)    outstanding_n = 1'b1;
      count_n = count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      outstanding <= 1'b0;
      count       <= '0;
      req_q       <= 1'b0;
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      rptr        <= '0;
      wptr        <= '0;
    end else begin
      state       <= state_n;
      outstanding <= outstanding_n;
      count       <= count_n;
      req_q       <= (state_n == RUN) && !outstanding_n && (count_n < CNT_W'(FIFO_DEPTH));
      if (redirect) begin
        fetch_pc <= target;
        rptr     <= '0;
        wptr     <= '0;
      end else begin
        if (ibus.req) begin
          fetch_pc <= fetch_pc + 32'd4;
          req_pc   <= fetch_pc;
        end
        if (push) wptr <= wptr + PTR_W'(1);
        if (pop)  rptr <= rptr + PTR_W'(1);
      end
    end
  end

  // Storage needs no reset: instr_valid gates every read.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= '{pc: req_pc, rdata: ibus.rdata};
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetches   <= 32'h0;
      perf_redirects <= 32'h0;
    end else begin
      if (push)     perf_fetches   <= perf_fetches + 32'd1;
      if (redirect) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`endif

  redirect_needs_valid: assert property (@(posedge clk) disable iff (!rst_n)
    ((state == RUN) && (branch || relative_jump || absolute_jump)) |-> instr_valid);

endmodule
